// File: rtl/token_sched_pkg.sv
// Shared sizing constants and channel/divisor types for the token round-robin scheduler.
package token_sched_pkg;

   localparam int NCH     = 4;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef logic [$clog2(NCH)-1:0] ch_id_t;
   typedef logic [1:0]             div_t;

endpackage

// File: rtl/token_decimator.sv
// Per-channel admission filter: keeps 1 of every (div+1) tokens on one serial stream.
module token_decimator
   import token_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tok,
   input  logic cfg_we,
   input  div_t cfg_div,
   output logic admit
);

   div_t div;
   div_t ph;

   // Admission uses the current phase, so a same-cycle reconfiguration only affects later tokens.
   assign admit = tok && (ph == 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= 2'd1;
         ph  <= 2'd0;
      end else if (cfg_we) begin
         div <= cfg_div;
         ph  <= 2'd0;
      end else if (tok) begin
         ph <= (ph == div) ? 2'd0 : ph + 2'd1;
      end
   end

endmodule

// File: rtl/token_rr_scheduler.sv
// Decimates NCH serial token streams, counts pending tokens per channel and offers them
// one per cycle to a ready/valid consumer in round-robin order.
module token_rr_scheduler
   import token_sched_pkg::*;
#(
   parameter int NCH   = token_sched_pkg::NCH,
   parameter int CNT_W = token_sched_pkg::CNT_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         in_tok,
   input  logic                   cfg_valid,
   input  logic [$clog2(NCH)-1:0] cfg_ch,
   input  div_t                   cfg_div,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(NCH)-1:0] out_id,
   output logic [NCH-1:0]         drop
);

   localparam int               ID_W     = $clog2(NCH);
   localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

   logic [NCH-1:0]   admit;
   logic [NCH-1:0]   grant;
   logic [NCH-1:0]   nz;
   logic [NCH-1:0]   drop_nxt;
   logic [CNT_W-1:0] cnt [NCH];
   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  hold_id;
   logic [ID_W-1:0]  rr_id;
   logic             hold_vld;
   logic             xfer;

   // First non-empty channel scanning cyclically from last+1; smallest offset wins.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NCH-1:0] req,
                                               input logic [ID_W-1:0] last);
      logic [ID_W-1:0] pick;
      int              idx;
      pick = last;
      for (int k = NCH; k >= 1; k--) begin
         idx = (int'(last) + k) % NCH;
         if (req[idx]) pick = ID_W'(idx);
      end
      return pick;
   endfunction

   for (genvar i = 0; i < NCH; i++) begin : g_dec
      token_decimator u_dec (
         .clk     (clk),
         .rst     (rst),
         .tok     (in_tok[i]),
         .cfg_we  (cfg_valid && (cfg_ch == ID_W'(i))),
         .cfg_div (cfg_div),
         .admit   (admit[i])
      );
   end

   // Offer path depends only on registered state.
   always_comb begin
      for (int i = 0; i < NCH; i++) nz[i] = (cnt[i] != '0);
   end

   assign out_valid = |nz;
   assign rr_id     = rr_pick(nz, last_grant);
   assign out_id    = hold_vld ? hold_id : rr_id;
   assign xfer      = out_valid && out_ready;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         grant[i]    = xfer && (out_id == ID_W'(i));
         drop_nxt[i] = admit[i] && !grant[i] && (cnt[i] == CNT_FULL);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) cnt[i] <= '0;
         drop <= '0;
      end else begin
         drop <= drop_nxt;
         for (int i = 0; i < NCH; i++) begin
            if (admit[i] && !grant[i]) begin
               if (cnt[i] != CNT_FULL) cnt[i] <= cnt[i] + 1'b1;
            end else if (grant[i] && !admit[i]) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

   // A stalled offer is locked so the consumer sees a stable channel until it accepts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= ID_W'(NCH - 1);
         hold_vld   <= 1'b0;
         hold_id    <= '0;
      end else if (xfer) begin
         last_grant <= out_id;
         hold_vld   <= 1'b0;
      end else if (out_valid) begin
         hold_vld   <= 1'b1;
         hold_id    <= out_id;
      end
   end

endmodule
